cmd_reply_engine: RTL and testbench
===================================

# cmd_reply_engine

Command decoder and reply generator on the host side of the FX2 interface. Consumes the byte stream delivered by the FX2 bidirectional FIFO bridge (`cmd`/`cmd_wr`), assembles framed register read/write commands, drives a simple register bus toward the time-tagger core, and returns framed reply packets over the bridge's reply channel (`reply`/`reply_rdy`/`reply_ack`/`reply_end`).

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16'd50000: idle cycles after which a partial frame is abandoned.

Ports:
- `fx2_clk`  in  1  sole clock; all logic rises on it.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd`  in  8  command byte from the bridge.
- `cmd_wr`  in  1  one-cycle strobe; `cmd` is valid this cycle.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  32  write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  32  read data; valid exactly 1 cycle after `reg_rd`.
- `reply`  out  8  reply byte.
- `reply_rdy`  out  1  `reply` is valid.
- `reply_ack`  in  1  bridge consumed the current byte.
- `reply_end`  out  1  current byte is the last of the packet.
- `overrun`  out  1  sticky: a `cmd_wr` byte was dropped.

## Operation
- Frame formats, bytes in arrival order:
  - Read: 0x01, addr.
  - Write: 0x02, addr, d0..d3. Data is little-endian; d0 lands in `reg_wdata[7:0]`.
- Reply packets:
  - Read: 0xA1, addr, r0..r3 (LE), 6 bytes.
  - Write: 0xA2, addr, 2 bytes.
  - Unknown opcode X: 0xEE, X, 2 bytes.
- States:
  - IDLE: a `cmd_wr` byte is the opcode. 0x01 or 0x02 -> ADDR. Any other value latches X and goes to REPLY with the error packet; the second reply byte is X.
  - ADDR: the next byte sets `reg_addr`. Read -> EXEC. Write -> DATA, with the byte counter cleared.
  - DATA: shift in 4 bytes, then -> EXEC.
  - EXEC, one cycle: pulse `reg_wr` (write) or `reg_rd` (read). Write -> REPLY. Read -> RD_WAIT.
  - RD_WAIT, one cycle: capture `reg_rdata` into the reply buffer, then -> REPLY.
  - REPLY: present the buffered bytes in order; -> IDLE after the last byte is acked.
- Frame timeout:
  - In ADDR or DATA, a 16-bit counter increments every cycle without `cmd_wr` and clears on `cmd_wr`.
  - When it reaches `TIMEOUT_CYCLES`, the partial frame is discarded silently: no bus strobe, no reply, -> IDLE.
- `cmd_wr` while in EXEC, RD_WAIT or REPLY: the byte is dropped and `overrun` is set. `overrun` clears only on `reset`.
- No command bytes are buffered. The host must wait for the reply before sending the next frame.

## Timing
- Reset values (asynchronous): state IDLE. `reply_rdy`, `reply_end`, `reg_wr`, `reg_rd` and `overrun` are 0. `reply`, `reg_addr` and `reg_wdata` are 0. Byte and timeout counters are 0.
- Latencies:
  - `reg_wr` / `reg_rd` assert the cycle after the clock edge that sampled the final frame byte.
  - Write: `reply_rdy` rises the cycle after `reg_wr`.
  - Read: `reply_rdy` rises 2 cycles after `reg_rd`.
- `reg_addr` and `reg_wdata` are stable from the strobe cycle until the next frame's ADDR byte.
- Reply handshake:
  - `reply_rdy` stays high and `reply` stays stable until an edge samples `reply_ack`=1.
  - On that edge the next byte is presented on the following cycle, so back-to-back acks give 1 byte/cycle.
  - `reply_end`=1 only while the final byte is presented.
  - After the final ack, `reply_rdy` is 0 the next cycle and the state is IDLE.
  - `reply_ack` while `reply_rdy`=0 is ignored.
- Simultaneous events:
  - `cmd_wr` on the same edge as the final ack: still counted as overrun, byte dropped.
  - `cmd_wr` on the timeout-expiry cycle: the byte is accepted and the counter is cleared, so no timeout occurs.
- `reset` asserted mid-packet: `reply_rdy` drops immediately (asynchronous) and the packet is truncated with no `reply_end`.

## Test plan
- Write frame 02 10 78 56 34 12 -> one `reg_wr` with `reg_addr`=0x10 and `reg_wdata`=0x12345678. Reply A2 10 with `reply_end` on byte 2.
- Read frame 01 20, model returns 0xDEADBEEF -> `reg_rd` once. Reply A1 20 EF BE AD DE, `reply_end` only on DE. Check the 2-cycle `reg_rd`-to-`reply_rdy` latency.
- Reply backpressure: hold `reply_ack` low for 7 cycles on each read-reply byte -> every byte is held stable and none is lost or duplicated.
- Opcode 0x55 -> reply EE 55, no bus strobe.
- Timeout: send 02 10 78, stall `TIMEOUT_CYCLES` cycles, then send 01 05 -> no `reg_wr`; read of 0x05 completes normally.
- Overrun and reset: send 01 07, then push a byte during REPLY -> `overrun`=1 and the reply is intact. Then assert `reset` mid-reply -> all outputs return to reset values and `overrun`=0.

Source files
------------

// File: rtl/cmd_reply_engine.sv
// cmd_reply_engine
// Host-side command decoder for the FX2 bridge. Bytes arrive one per cmd_wr
// strobe and are assembled into register read/write frames. Each frame
// drives one bus strobe, and the engine returns a framed reply packet.
//
// Reply channel handshake: a byte is transferred on every rising edge where
// reply_rdy and reply_ack are both 1. reply and reply_end hold steady until
// that edge. The next byte is presented on the following cycle. reply_ack is
// ignored while reply_rdy is 0.
//
// Command channel: there is no backpressure. A cmd_wr byte arriving while a
// frame is executing or replying is dropped and sets the sticky overrun flag.

module cmd_reply_engine #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        fx2_clk,
  input  logic        reset,
  input  logic [7:0]  cmd,
  input  logic        cmd_wr,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  output logic [7:0]  reply,
  output logic        reply_rdy,
  input  logic        reply_ack,
  output logic        reply_end,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] HDR_READ = 8'hA1;
  localparam logic [7:0] HDR_WR   = 8'hA2;
  localparam logic [7:0] HDR_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_EXEC    = 3'd3,
    S_RD_WAIT = 3'd4,
    S_REPLY   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_is_write;   // opcode of the frame in progress
  logic [1:0]  r_byte_cnt;   // data bytes received so far in DATA
  logic [15:0] r_tmo_cnt;    // idle cycles since the last frame byte
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_hdr;        // first reply byte
  logic [7:0]  r_arg;        // second reply byte: address or bad opcode
  logic [31:0] r_rbuf;       // captured read data
  logic [2:0]  r_idx;        // reply byte currently presented
  logic        r_overrun;

  logic        w_in_frame;
  logic        w_tmo_hit;
  logic        w_busy;
  logic [2:0]  w_last_idx;
  logic        w_on_last;
  logic [7:0]  w_reply_byte;

  // A partial frame expires only on an idle cycle. A byte arriving on the
  // expiry cycle wins and restarts the count.
  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tmo_hit  = w_in_frame && !cmd_wr && (r_tmo_cnt == TIMEOUT_CYCLES);
  assign w_busy     = (r_state == S_EXEC) || (r_state == S_RD_WAIT) ||
                      (r_state == S_REPLY);
  // Read replies are 6 bytes long; write and error replies are 2 bytes.
  assign w_last_idx = (r_hdr == HDR_READ) ? 3'd5 : 3'd1;
  assign w_on_last  = (r_idx == w_last_idx);

  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; the strobes and reply outputs follow the state.
  always_comb begin
    w_next    = r_state;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    reply_rdy = 1'b0;
    reply_end = 1'b0;
    reply     = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (cmd_wr) begin
          if ((cmd == OP_READ) || (cmd == OP_WRITE)) begin
            w_next = S_ADDR;
          end else begin
            w_next = S_REPLY;
          end
        end
      end
      S_ADDR: begin
        if (cmd_wr) begin
          w_next = r_is_write ? S_DATA : S_EXEC;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (cmd_wr) begin
          if (r_byte_cnt == 2'd3) begin
            w_next = S_EXEC;
          end
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: begin
        reg_wr = r_is_write;
        reg_rd = !r_is_write;
        w_next = r_is_write ? S_REPLY : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_next = S_REPLY;
      end
      S_REPLY: begin
        reply_rdy = 1'b1;
        reply     = w_reply_byte;
        reply_end = w_on_last;
        if (reply_ack && w_on_last) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Select the reply byte at the current packet index.
  always_comb begin
    w_reply_byte = r_rbuf[31:24];
    case (r_idx)
      3'd0:    w_reply_byte = r_hdr;
      3'd1:    w_reply_byte = r_arg;
      3'd2:    w_reply_byte = r_rbuf[7:0];
      3'd3:    w_reply_byte = r_rbuf[15:8];
      3'd4:    w_reply_byte = r_rbuf[23:16];
      default: w_reply_byte = r_rbuf[31:24];
    endcase
  end

  // Capture the opcode, address and little-endian write data.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_addr     <= 8'h00;
      r_wdata    <= 32'h0;
      r_hdr      <= 8'h00;
      r_arg      <= 8'h00;
    end else if (cmd_wr) begin
      case (r_state)
        S_IDLE: begin
          r_is_write <= (cmd == OP_WRITE);
          if (cmd == OP_READ) begin
            r_hdr <= HDR_READ;
          end else if (cmd == OP_WRITE) begin
            r_hdr <= HDR_WR;
          end else begin
            r_hdr <= HDR_ERR;
            r_arg <= cmd;
          end
        end
        S_ADDR: begin
          r_addr     <= cmd;
          r_arg      <= cmd;
          r_byte_cnt <= 2'd0;
        end
        S_DATA: begin
          // After four shifts, the first data byte sits in bits [7:0].
          r_wdata    <= {cmd, r_wdata[31:8]};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Frame inactivity counter. It runs only while a frame is partially received.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= 16'd0;
    end else if (!w_in_frame || cmd_wr || w_tmo_hit) begin
      r_tmo_cnt <= 16'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Latch read data one cycle after reg_rd, and step through the reply bytes.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      r_rbuf <= 32'h0;
      r_idx  <= 3'd0;
    end else begin
      if (r_state == S_RD_WAIT) begin
        r_rbuf <= reg_rdata;
      end
      if (r_state != S_REPLY) begin
        r_idx <= 3'd0;
      end else if (reply_ack) begin
        r_idx <= w_on_last ? 3'd0 : (r_idx + 3'd1);
      end
    end
  end

  // Sticky flag: a command byte arrived while the engine could not take it.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (cmd_wr && w_busy) begin
      r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_reply_engine.sv
// Directed bench for cmd_reply_engine: write/read/error frames, reply
// backpressure, frame timeout and its boundary, overrun, and reset mid-reply.

module tb_cmd_reply_engine;

  localparam logic [15:0] TMO = 16'd40;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_REPLY   = 3'd5;

  logic        fx2_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cmd = 8'h00;
  logic        cmd_wr = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata = 32'h0;
  logic [7:0]  reply;
  logic        reply_rdy;
  logic        reply_ack = 1'b0;
  logic        reply_end;
  logic        overrun;
  logic [2:0]  dbg_state;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic [31:0] rd_model = 32'h0;
  logic [7:0]  exp_q[$];

  cmd_reply_engine #(.TIMEOUT_CYCLES(TMO)) dut (
    .fx2_clk(fx2_clk), .reset(reset), .cmd(cmd), .cmd_wr(cmd_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reply(reply),
    .reply_rdy(reply_rdy), .reply_ack(reply_ack), .reply_end(reply_end),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock and register-bus model: read data is valid one cycle after reg_rd.
  always #5 fx2_clk = ~fx2_clk;

  always @(posedge fx2_clk) begin
    reg_rdata <= reg_rd ? rd_model : 32'h0;
    if (reg_wr) n_wr++;
    if (reg_rd) n_rd++;
  end

  task automatic tick();
    @(posedge fx2_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd = b;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  // Drain the expected reply bytes, holding ack low for 'hold' cycles per byte.
  task automatic rx_reply(input int hold);
    logic [7:0] e;
    logic [7:0] cur;
    int w;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = 0;
      while (!reply_rdy && w < 20) begin
        tick();
        w++;
      end
      chk("rdy_wait", {31'd0, reply_rdy}, 32'd1);
      cur = reply;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_byte", {24'd0, reply}, {24'd0, cur});
        chk("hold_rdy", {31'd0, reply_rdy}, 32'd1);
      end
      chk("reply_byte", {24'd0, reply}, {24'd0, e});
      chk("reply_end", {31'd0, reply_end}, {31'd0, (exp_q.size() == 0)});
      reply_ack = 1'b1;
      tick();
      reply_ack = 1'b0;
    end
    chk("rdy_after_pkt", {31'd0, reply_rdy}, 32'd0);
    chk("idle_after_pkt", {29'd0, dbg_state}, {29'd0, ST_IDLE});
  endtask

  initial begin
    // Reset
    idle(3);
    reset = 1'b0;
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_outs", {reply_rdy, reply_end, reg_wr, reg_rd, overrun, reply},
        32'h0);
    chk("rst_addr", {24'd0, reg_addr}, 32'h0);
    chk("rst_wdata", reg_wdata, 32'h0);

    // A stray ack while no reply is pending is ignored.
    reply_ack = 1'b1;
    tick();
    reply_ack = 1'b0;
    chk("stray_ack", {26'd0, reply_rdy, dbg_state}, {26'd0, 1'b0, ST_IDLE});

    // Write frame 02 10 78 56 34 12
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h78);
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("wr_strobe", {31'd0, reg_wr}, 32'd1);
    chk("wr_addr", {24'd0, reg_addr}, 32'h10);
    chk("wr_data", reg_wdata, 32'h12345678);
    chk("wr_rdy_early", {31'd0, reply_rdy}, 32'd0);
    tick();
    chk("wr_strobe_off", {31'd0, reg_wr}, 32'd0);
    chk("wr_rdy_lat", {31'd0, reply_rdy}, 32'd1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h10);
    rx_reply(0);
    chk("wr_count", n_wr, 32'd1);
    chk("wr_data_hold", reg_wdata, 32'h12345678);

    // Read frame 01 20, back-to-back acks
    rd_model = 32'hDEADBEEF;
    send_byte(8'h01); send_byte(8'h20);
    chk("rd_strobe", {31'd0, reg_rd}, 32'd1);
    chk("rd_addr", {24'd0, reg_addr}, 32'h20);
    tick();
    chk("rd_wait_state", {29'd0, dbg_state}, {29'd0, ST_RD_WAIT});
    chk("rd_rdy_1cyc", {31'd0, reply_rdy}, 32'd0);
    tick();
    chk("rd_rdy_2cyc", {31'd0, reply_rdy}, 32'd1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h20); exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    rx_reply(0);
    chk("rd_count", n_rd, 32'd1);

    // Read with backpressure: ack held low for 7 cycles on every byte
    rd_model = 32'hCAFEF00D;
    send_byte(8'h01); send_byte(8'h21);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h21); exp_q.push_back(8'h0D);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    rx_reply(7);
    chk("bp_rd_count", n_rd, 32'd2);

    // Unknown opcode
    send_byte(8'h55);
    chk("err_state", {29'd0, dbg_state}, {29'd0, ST_REPLY});
    exp_q.push_back(8'hEE); exp_q.push_back(8'h55);
    rx_reply(0);
    chk("err_no_strobe", n_wr + n_rd, 32'd3);

    // Timeout: partial write abandoned after TMO idle cycles
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h78);
    idle(TMO);
    chk("tmo_not_yet", {29'd0, dbg_state}, {29'd0, ST_DATA});
    tick();
    chk("tmo_expired", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rd_model = 32'h0BADF00D;
    send_byte(8'h01); send_byte(8'h05);
    chk("tmo_rd_strobe", {31'd0, reg_rd}, 32'd1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h05); exp_q.push_back(8'h0D);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hAD); exp_q.push_back(8'h0B);
    rx_reply(0);
    chk("tmo_no_write", n_wr, 32'd1);
    chk("tmo_rd_count", n_rd, 32'd3);

    // A byte landing on the expiry cycle is accepted
    send_byte(8'h02);
    idle(TMO);
    chk("edge_state", {29'd0, dbg_state}, {29'd0, ST_ADDR});
    send_byte(8'h30);
    chk("edge_accept", {29'd0, dbg_state}, {29'd0, ST_DATA});
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("edge_wr", {31'd0, reg_wr}, 32'd1);
    chk("edge_wdata", reg_wdata, 32'h04030201);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h30);
    rx_reply(0);
    chk("edge_wr_count", n_wr, 32'd2);

    // Overrun: byte pushed during REPLY is dropped, reply intact
    rd_model = 32'h11223344;
    send_byte(8'h01); send_byte(8'h07);
    idle(2);
    chk("ovr_clear", {31'd0, overrun}, 32'd0);
    send_byte(8'h99);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h07); exp_q.push_back(8'h44);
    exp_q.push_back(8'h33); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    rx_reply(0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset asserted mid-reply
    rd_model = 32'h55667788;
    send_byte(8'h01); send_byte(8'h08);
    idle(2);
    reply_ack = 1'b1;
    tick(); tick();
    reply_ack = 1'b0;
    chk("mid_byte", {24'd0, reply}, 32'h88);
    #2 reset = 1'b1;
    #1;
    chk("async_rdy", {31'd0, reply_rdy}, 32'd0);
    chk("async_outs", {reply_end, reg_wr, reg_rd, overrun, reply}, 32'h0);
    chk("async_regs", {reg_addr, reg_wdata[23:0]}, 32'h0);
    chk("async_wdata_hi", {24'd0, reg_wdata[31:24]}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Engine still functional after reset
    send_byte(8'hFF);
    exp_q.push_back(8'hEE); exp_q.push_back(8'hFF);
    rx_reply(0);
    chk("post_rst_ovr", {31'd0, overrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
